// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, status/divisor registers and a serializer FSM.
// Sits on the RAM-style responder port with one-cycle registered read data.
module uart_tx_mmio #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned FIFO_LOG2   = 3,
    parameter int unsigned DEFAULT_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:2] addr,
    input  logic [31:0]           din,
    input  logic [3:0]            bwe,
    input  logic                  ren,
    output logic [31:0]           dout,
    output logic                  txd,
    output logic                  tx_idle
);

    localparam int unsigned AW    = ADDR_WIDTH - 2;
    localparam int unsigned Depth = 1 << FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q;
    logic                 txd_q;
    logic [7:0]           shift_q;
    logic [15:0]          bitdiv_q;
    logic [15:0]          cnt_q;
    logic [2:0]           bitcnt_q;
    logic [15:0]          div_q;
    logic                 ovf_q;
    logic [31:0]          dout_q;
    logic [FIFO_LOG2-1:0] wptr_q, rptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           mem_q [Depth];

    logic        empty, full, bit_end, pop, push_req, push, ovf_clr, sel_div;
    logic [15:0] eff_div;
    logic [31:0] status, rdata;
    logic        unused_ok;

    assign unused_ok = ^{din[31:16], bwe[3:2]};

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(Depth));
        eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;
        bit_end  = (cnt_q == bitdiv_q - 16'd1);
        // The FSM pops either from IDLE or at the last cycle of a stop bit.
        pop      = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
        push_req = (addr == AW'(0)) && bwe[0];
        push     = push_req && (!full || pop);
        ovf_clr  = (addr == AW'(1)) && bwe[0] && din[3];
        sel_div  = (addr == AW'(2));

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        status          = '0;
        status[0]       = (state_q != StIdle);
        status[1]       = full;
        status[2]       = empty;
        status[3]       = ovf_q;
        status[8 +: CW] = count_q;

        rdata = '0;
        if (addr == AW'(1)) begin
            rdata = status;
        end else if (addr == AW'(2)) begin
            rdata = {16'd0, div_q};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= 16'(DEFAULT_DIV);
            dout_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + FIFO_LOG2'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_LOG2'(1);
            end
            count_q <= count_d;
            if (push_req && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (sel_div && bwe[0]) begin
                div_q[7:0] <= din[7:0];
            end
            if (sel_div && bwe[1]) begin
                div_q[15:8] <= din[15:8];
            end
            // Read data reflects register state before any same-cycle write.
            if (ren) begin
                dout_q <= rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            txd_q    <= 1'b1;
            shift_q  <= '0;
            bitdiv_q <= 16'd1;
            cnt_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            case (state_q)
                StIdle, StStop: begin
                    if (state_q == StStop && !bit_end) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else if (pop) begin
                        shift_q  <= mem_q[rptr_q];
                        bitdiv_q <= eff_div;
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        txd_q    <= 1'b0;
                        state_q  <= StStart;
                    end else begin
                        cnt_q   <= '0;
                        txd_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else if (bitcnt_q == 3'd7) begin
                        cnt_q   <= '0;
                        txd_q   <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q    <= '0;
                        shift_q  <= shift_q >> 1;
                        txd_q    <= shift_q[1];
                        bitcnt_q <= bitcnt_q + 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dout    = dout_q;
    assign txd     = txd_q;
    assign tx_idle = empty && (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized scoreboard bench for uart_tx_mmio: expected frames and read data are queued at
// stimulus time and checked by independent line and read-port monitors.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:2]  addr;
    logic [31:0] din;
    logic [3:0]  bwe;
    logic        ren;
    logic [31:0] dout;
    logic        txd;
    logic        tx_idle;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .ADDR_WIDTH (4),
        .FIFO_LOG2  (3),
        .DEFAULT_DIV(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .din    (din),
        .bwe    (bwe),
        .ren    (ren),
        .dout   (dout),
        .txd    (txd),
        .tx_idle(tx_idle)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } frame_t;

    frame_t      fq[$];
    logic [31:0] rq[$];
    string       rn[$];
    int          vecs = 0;
    int          errs = 0;
    bit          in_frame = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] st(bit busy, bit fl, bit em, bit ovf, int cnt);
        logic [31:0] v;
        v       = '0;
        v[0]    = busy;
        v[1]    = fl;
        v[2]    = em;
        v[3]    = ovf;
        v[11:8] = 4'(cnt);
        return v;
    endfunction

    task automatic idle_bus();
        addr = '0;
        din  = '0;
        bwe  = '0;
        ren  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a;
        din  = d;
        bwe  = be;
        ren  = 1'b0;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        rq.push_back(e);
        rn.push_back(n);
        addr = a;
        bwe  = '0;
        ren  = 1'b1;
        @(negedge clk);
        idle_bus();
    endtask

    // Expected line behaviour: 8N1 frame, LSB first, each bit max(div,1) clocks.
    task automatic exp_frame(input logic [7:0] d, input int div, input bit b2b);
        frame_t f;
        f.data = d;
        f.div  = (div == 0) ? 1 : div;
        f.b2b  = b2b;
        fq.push_back(f);
    endtask

    task automatic send(input logic [7:0] d, input int div, input bit b2b);
        exp_frame(d, div, b2b);
        wr(2'd0, {24'd0, d}, 4'b0001);
    endtask

    task automatic wait_drain(input int limit);
        for (int c = 0; c < limit; c++) begin
            if (fq.size() == 0 && !in_frame && tx_idle === 1'b1) return;
            @(negedge clk);
        end
        vecs++;
        errs++;
        $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", fq.size(), limit);
    endtask

    // Read-port monitor: a read sampled at a rising edge is visible on dout at the next falling edge.
    initial begin
        bit r;
        forever begin
            @(posedge clk);
            r = ren && !reset;
            @(negedge clk);
            if (r) begin
                if (rq.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_read: dout 0x%08h, no read queued", dout);
                end else begin
                    check(rn.pop_front(), dout, rq.pop_front());
                end
            end
        end
    end

    // Line monitor: decodes each start bit against the next queued expected frame.
    initial begin
        int         gap;
        bit         chk_idle;
        bit         aborted;
        int         bad;
        int         n;
        frame_t     e;
        logic [9:0] bits;
        gap      = 0;
        chk_idle = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gap      = 0;
                chk_idle = 0;
                continue;
            end
            if (chk_idle) begin
                check("tx_idle_after_stop", {31'd0, tx_idle}, 32'd1);
                chk_idle = 0;
            end
            if (txd === 1'b1) begin
                gap++;
            end else if (fq.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_frame: txd low with no byte queued");
                while (txd !== 1'b1 && !reset) @(negedge clk);
                gap = 0;
            end else begin
                in_frame = 1;
                e        = fq.pop_front();
                if (e.b2b) check("b2b_gap", gap, 0);
                bits    = {1'b1, e.data, 1'b0};
                n       = 10 * e.div;
                bad     = 0;
                aborted = 0;
                for (int i = 1; i < n; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1;
                        break;
                    end
                    if (txd !== bits[i / e.div]) bad++;
                end
                in_frame = 0;
                gap      = 0;
                if (!aborted) begin
                    check($sformatf("frame_%02h_div%0d_badbits", e.data, e.div), bad, 0);
                    chk_idle = (fq.size() == 0);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        int         d;
        int         n;
        idle_bus();
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("rst_dout", dout, 32'd0);
        reset = 1'b0;

        rd(2'd1, 32'h0000_0004, "status_after_reset");
        rd(2'd2, 32'h0000_0010, "div_after_reset");
        rd(2'd0, 32'h0, "data_reads_zero");
        wr(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd(2'd3, 32'h0, "reserved_reads_zero");
        rd(2'd2, 32'h0000_0010, "div_unchanged_by_reserved");
        check("txd_idle_high", {31'd0, txd}, 32'd1);

        // Single 0x55 at DIV=4, with busy/count timing around the first pop.
        wr(2'd2, 32'd4, 4'b0011);
        send(8'h55, 4, 0);
        rd(2'd1, st(0, 0, 0, 0, 1), "status_before_pop");
        rd(2'd1, st(1, 0, 1, 0, 0), "status_busy");
        wait_drain(100);
        rd(2'd1, st(0, 0, 1, 0, 0), "status_done_55");

        // Nine queued bytes at DIV=2; a tenth write finds the FIFO full.
        wr(2'd2, 32'd2, 4'b0011);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (i < 9) exp_frame(b, 2, i != 0);
            wr(2'd0, {24'd0, b}, 4'b0001);
        end
        rd(2'd1, st(1, 1, 0, 1, 8), "status_overflow");
        wr(2'd1, 32'h0000_0008, 4'b0001);
        rd(2'd1, st(1, 1, 0, 0, 8), "status_overflow_cleared");
        wait_drain(400);

        // Byte-wise divisor writes.
        wr(2'd2, 32'h0000_1234, 4'b0011);
        wr(2'd2, 32'h0000_FF05, 4'b0001);
        rd(2'd2, 32'h0000_1205, "div_low_byte");
        wr(2'd2, 32'h0000_0077, 4'b0010);
        rd(2'd2, 32'h0000_0005, "div_high_byte");

        // Random bursts at random divisors.
        for (int r = 0; r < 4; r++) begin
            d = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            wr(2'd2, d, 4'b0011);
            for (int k = 0; k < n; k++) send(8'($urandom), d, k != 0);
            wait_drain(10 * d * n + 50);
        end

        // Divisor change while a frame is in flight only affects the next frame.
        wr(2'd2, 32'd2, 4'b0011);
        b  = 8'($urandom);
        b2 = 8'($urandom);
        send(b, 2, 0);
        send(b2, 8, 1);
        repeat (5) @(negedge clk);
        wr(2'd2, 32'd8, 4'b0011);
        wait_drain(200);

        // DIV=0 behaves as one clock per bit.
        wr(2'd2, 32'd0, 4'b0011);
        rd(2'd2, 32'd0, "div_zero_readback");
        send(8'hA3, 0, 0);
        wait_drain(50);

        // Reset in the middle of a data bit with three bytes still queued.
        wr(2'd2, 32'd4, 4'b0011);
        send(8'($urandom), 4, 0);
        for (int k = 0; k < 3; k++) wr(2'd0, {24'd0, 8'($urandom)}, 4'b0001);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_rst_txd", {31'd0, txd}, 32'd1);
        check("midframe_rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("midframe_rst_dout", dout, 32'd0);
        reset = 1'b0;
        rd(2'd1, 32'h0000_0004, "status_after_midframe_reset");
        rd(2'd2, 32'h0000_0010, "div_after_midframe_reset");
        repeat (100) @(negedge clk);
        check("txd_quiet_after_reset", {31'd0, txd}, 32'd1);
        check("tx_idle_after_reset", {31'd0, tx_idle}, 32'd1);

        repeat (2) @(negedge clk);
        if (rq.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL reads_unanswered: %0d reads never returned", rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
